// File: rtl/rv_plic_claim_ctrl.sv
// Per-target PLIC claim/complete controller: claim handshake FSM with post-claim
// irq blanking, one-hot gateway claim/complete pulses and the claimed-ID bitmap.
module rv_plic_claim_ctrl #(
  parameter  int N_SOURCE     = 32,
  parameter  int BLANK_CYCLES = 2,
  localparam int SrcWidth     = $clog2(N_SOURCE)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                irq_i,
  input  logic [SrcWidth-1:0] irq_id_i,
  input  logic                claim_req_i,
  output logic                claim_ready_o,
  output logic                claim_rsp_valid_o,
  output logic [SrcWidth-1:0] claim_id_o,
  input  logic                complete_req_i,
  input  logic [SrcWidth-1:0] complete_id_i,
  output logic                complete_err_o,
  output logic [N_SOURCE-1:0] claim_o,
  output logic [N_SOURCE-1:0] complete_o,
  output logic [N_SOURCE-1:0] claimed_o,
  output logic                irq_o
);

  if (BLANK_CYCLES < 1 || BLANK_CYCLES > 15) begin : g_bad_blank
    $error("BLANK_CYCLES must be in 1..15");
  end

  typedef enum logic [1:0] {IDLE, RESP, BLANK} state_e;

  state_e              state_q;
  logic [3:0]          blank_cnt_q;
  logic                ready_q;
  logic                rsp_valid_q;
  logic [SrcWidth-1:0] claim_id_q;
  logic [N_SOURCE-1:0] claim_q;
  logic [N_SOURCE-1:0] claimed_q, claimed_d;
  logic [N_SOURCE-1:0] complete_q, complete_d;
  logic                complete_err_q, complete_err_d;
  logic [SrcWidth-1:0] cap_id;
  logic [N_SOURCE-1:0] complete_hot;
  logic                complete_legal;

  // ID 0 and out-of-range IDs decode to no gateway at all.
  function automatic logic [N_SOURCE-1:0] id_to_onehot(input logic [SrcWidth-1:0] id);
    id_to_onehot = '0;
    if (id != '0 && int'(id) < N_SOURCE) id_to_onehot[id] = 1'b1;
  endfunction

  assign cap_id = irq_i ? irq_id_i : '0;

  // Registered ready doubles as the "FSM is in IDLE" flag for irq gating, so
  // both stay low throughout reset and the first cycle after release.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      blank_cnt_q <= '0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      claim_id_q  <= '0;
      claim_q     <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      claim_id_q  <= '0;
      claim_q     <= '0;
      case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          if (claim_req_i && ready_q) begin
            state_q     <= RESP;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b1;
            claim_id_q  <= cap_id;
            claim_q     <= id_to_onehot(cap_id);
          end
        end
        RESP: begin
          state_q     <= BLANK;
          blank_cnt_q <= 4'(BLANK_CYCLES);
        end
        BLANK: begin
          if (blank_cnt_q == 4'd1) begin
            state_q     <= IDLE;
            blank_cnt_q <= '0;
            ready_q     <= 1'b1;
          end else begin
            blank_cnt_q <= blank_cnt_q - 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // A complete is judged against the registered bitmap, so one racing the RESP
  // of the same ID still sees the bit clear.
  // NOTE: every always_comb output gets a default first; no path may leave one unassigned (latch).
  always_comb begin
    complete_hot   = id_to_onehot(complete_id_i);
    complete_legal = complete_req_i && |(complete_hot & claimed_q);
    complete_d     = complete_legal ? complete_hot : '0;
    complete_err_d = complete_req_i && !complete_legal;
    claimed_d      = (claimed_q & ~complete_q) | claim_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      claimed_q      <= '0;
      complete_q     <= '0;
      complete_err_q <= 1'b0;
    end else begin
      claimed_q      <= claimed_d;
      complete_q     <= complete_d;
      complete_err_q <= complete_err_d;
    end
  end

  assign claim_ready_o     = ready_q;
  assign claim_rsp_valid_o = rsp_valid_q;
  assign claim_id_o        = claim_id_q;
  assign claim_o           = claim_q;
  assign complete_o        = complete_q;
  assign complete_err_o    = complete_err_q;
  assign claimed_o         = claimed_q;
  assign irq_o             = irq_i & ready_q;

  a_claim_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(claim_o));
  a_complete_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(complete_o));

endmodule

// File: tb/tb_rv_plic_claim_ctrl.sv
// Directed bench for rv_plic_claim_ctrl: claim latency, blanking, complete
// legality, back-to-back claims and mid-response reset.
module tb_rv_plic_claim_ctrl;

  localparam int N_SOURCE = 32;
  localparam int SW       = 5;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          irq_i;
  logic [SW-1:0] irq_id_i;
  logic          claim_req_i;
  logic          claim_ready_o;
  logic          claim_rsp_valid_o;
  logic [SW-1:0] claim_id_o;
  logic          complete_req_i;
  logic [SW-1:0] complete_id_i;
  logic          complete_err_o;
  logic [31:0]   claim_o;
  logic [31:0]   complete_o;
  logic [31:0]   claimed_o;
  logic          irq_o;

  int vectors = 0;
  int errors  = 0;

  rv_plic_claim_ctrl #(.N_SOURCE(N_SOURCE), .BLANK_CYCLES(2)) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .irq_i             (irq_i),
    .irq_id_i          (irq_id_i),
    .claim_req_i       (claim_req_i),
    .claim_ready_o     (claim_ready_o),
    .claim_rsp_valid_o (claim_rsp_valid_o),
    .claim_id_o        (claim_id_o),
    .complete_req_i    (complete_req_i),
    .complete_id_i     (complete_id_i),
    .complete_err_o    (complete_err_o),
    .claim_o           (claim_o),
    .complete_o        (complete_o),
    .claimed_o         (claimed_o),
    .irq_o             (irq_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; irq_i = 1'b1; irq_id_i = '0; claim_req_i = 1'b0;
    complete_req_i = 1'b0; complete_id_i = '0;
    #12;
    vectors++; if (claim_ready_o !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", claim_ready_o); end
    vectors++; if (irq_o !== 1'b0) begin errors++; $display("FAIL rst_irq: got %b want 0", irq_o); end
    vectors++; if (claimed_o !== 32'h0) begin errors++; $display("FAIL rst_claimed: got %h want 0", claimed_o); end
    vectors++; if ({claim_rsp_valid_o, complete_err_o, claim_o, complete_o} !== '0) begin errors++; $display("FAIL rst_pulses: got nonzero"); end
    @(negedge clk_i); rst_ni = 1'b1;
    tick();
    vectors++; if (claim_ready_o !== 1'b1) begin errors++; $display("FAIL rel_ready: got %b want 1", claim_ready_o); end
    vectors++; if (irq_o !== 1'b1) begin errors++; $display("FAIL rel_irq: got %b want 1", irq_o); end
  endtask

  task automatic test_claim();
    irq_i = 1'b1; irq_id_i = 5'd5; claim_req_i = 1'b1;
    tick();
    claim_req_i = 1'b0;
    vectors++; if (claim_rsp_valid_o !== 1'b1) begin errors++; $display("FAIL claim_rsp: got %b want 1", claim_rsp_valid_o); end
    vectors++; if (claim_id_o !== 5'd5) begin errors++; $display("FAIL claim_id: got %0d want 5", claim_id_o); end
    vectors++; if (claim_o !== 32'h20) begin errors++; $display("FAIL claim_pulse: got %h want 20", claim_o); end
    vectors++; if ({irq_o, claim_ready_o} !== 2'b00) begin errors++; $display("FAIL claim_resp_mask: got %b want 00", {irq_o, claim_ready_o}); end
    tick();
    vectors++; if (claimed_o !== 32'h20) begin errors++; $display("FAIL claim_bitmap: got %h want 20", claimed_o); end
    vectors++; if ({claim_rsp_valid_o, claim_id_o, claim_o} !== '0) begin errors++; $display("FAIL claim_rsp_drop: got nonzero"); end
    vectors++; if ({irq_o, claim_ready_o} !== 2'b00) begin errors++; $display("FAIL blank1_mask: got %b want 00", {irq_o, claim_ready_o}); end
    tick();
    vectors++; if ({irq_o, claim_ready_o} !== 2'b00) begin errors++; $display("FAIL blank2_mask: got %b want 00", {irq_o, claim_ready_o}); end
    tick();
    vectors++; if ({irq_o, claim_ready_o} !== 2'b11) begin errors++; $display("FAIL claim_reready: got %b want 11", {irq_o, claim_ready_o}); end
  endtask

  task automatic test_claim_no_irq();
    irq_i = 1'b0; irq_id_i = 5'd12; claim_req_i = 1'b1;
    tick();
    claim_req_i = 1'b0;
    vectors++; if ({claim_rsp_valid_o, claim_id_o} !== {1'b1, 5'd0}) begin errors++; $display("FAIL noirq_rsp: got %b/%0d want 1/0", claim_rsp_valid_o, claim_id_o); end
    vectors++; if (claim_o !== 32'h0) begin errors++; $display("FAIL noirq_pulse: got %h want 0", claim_o); end
    tick();
    vectors++; if (claimed_o !== 32'h20) begin errors++; $display("FAIL noirq_bitmap: got %h want 20", claimed_o); end
    tick(); tick();
    vectors++; if (claim_ready_o !== 1'b1) begin errors++; $display("FAIL noirq_reready: got %b want 1", claim_ready_o); end
    irq_i = 1'b1;
  endtask

  task automatic test_complete();
    complete_req_i = 1'b1; complete_id_i = 5'd5;
    tick();
    complete_req_i = 1'b0;
    vectors++; if (complete_o !== 32'h20) begin errors++; $display("FAIL cpl_pulse: got %h want 20", complete_o); end
    vectors++; if (complete_err_o !== 1'b0) begin errors++; $display("FAIL cpl_err: got %b want 0", complete_err_o); end
    tick();
    vectors++; if (claimed_o !== 32'h0) begin errors++; $display("FAIL cpl_bitmap: got %h want 0", claimed_o); end
    vectors++; if (complete_o !== 32'h0) begin errors++; $display("FAIL cpl_drop: got %h want 0", complete_o); end
  endtask

  task automatic test_complete_illegal();
    complete_req_i = 1'b1; complete_id_i = 5'd7;
    tick();
    complete_id_i = 5'd0;
    vectors++; if ({complete_err_o, complete_o} !== {1'b1, 32'h0}) begin errors++; $display("FAIL ill7: got err=%b cpl=%h want 1/0", complete_err_o, complete_o); end
    tick();
    complete_req_i = 1'b0;
    vectors++; if ({complete_err_o, complete_o} !== {1'b1, 32'h0}) begin errors++; $display("FAIL ill0: got err=%b cpl=%h want 1/0", complete_err_o, complete_o); end
    tick();
    vectors++; if (complete_err_o !== 1'b0) begin errors++; $display("FAIL ill_drop: got %b want 0", complete_err_o); end
  endtask

  task automatic test_complete_during_resp();
    irq_id_i = 5'd6; claim_req_i = 1'b1;
    tick();
    claim_req_i = 1'b0; complete_req_i = 1'b1; complete_id_i = 5'd6;
    vectors++; if (claim_o !== 32'h40) begin errors++; $display("FAIL race_claim: got %h want 40", claim_o); end
    tick();
    complete_req_i = 1'b0;
    vectors++; if ({complete_err_o, complete_o} !== {1'b1, 32'h0}) begin errors++; $display("FAIL race_err: got err=%b cpl=%h want 1/0", complete_err_o, complete_o); end
    vectors++; if (claimed_o !== 32'h40) begin errors++; $display("FAIL race_bitmap: got %h want 40", claimed_o); end
    tick(); tick();
    vectors++; if (claim_ready_o !== 1'b1) begin errors++; $display("FAIL race_reready: got %b want 1", claim_ready_o); end
  endtask

  task automatic test_back_to_back();
    irq_id_i = 5'd3; claim_req_i = 1'b1; complete_req_i = 1'b1; complete_id_i = 5'd6;
    tick();
    complete_req_i = 1'b0; irq_id_i = 5'd9;
    vectors++; if ({claim_rsp_valid_o, claim_id_o} !== {1'b1, 5'd3}) begin errors++; $display("FAIL b2b_rsp1: got %b/%0d want 1/3", claim_rsp_valid_o, claim_id_o); end
    vectors++; if ({claim_o, complete_o} !== {32'h08, 32'h40}) begin errors++; $display("FAIL b2b_pulses: got %h/%h want 08/40", claim_o, complete_o); end
    tick();
    vectors++; if (claimed_o !== 32'h08) begin errors++; $display("FAIL b2b_setclr: got %h want 08", claimed_o); end
    vectors++; if (claim_ready_o !== 1'b0) begin errors++; $display("FAIL b2b_hold1: got %b want 0", claim_ready_o); end
    tick();
    vectors++; if ({claim_ready_o, claim_rsp_valid_o} !== 2'b00) begin errors++; $display("FAIL b2b_hold2: got %b want 00", {claim_ready_o, claim_rsp_valid_o}); end
    tick();
    vectors++; if (claim_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_accept: got %b want 1", claim_ready_o); end
    tick();
    claim_req_i = 1'b0;
    vectors++; if ({claim_rsp_valid_o, claim_id_o} !== {1'b1, 5'd9}) begin errors++; $display("FAIL b2b_rsp2: got %b/%0d want 1/9", claim_rsp_valid_o, claim_id_o); end
    vectors++; if (claim_o !== 32'h200) begin errors++; $display("FAIL b2b_claim2: got %h want 200", claim_o); end
    tick();
    vectors++; if (claimed_o !== 32'h208) begin errors++; $display("FAIL b2b_bitmap: got %h want 208", claimed_o); end
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    irq_id_i = 5'd4; claim_req_i = 1'b1;
    tick();
    vectors++; if (claim_o !== 32'h10) begin errors++; $display("FAIL mid_claim: got %h want 10", claim_o); end
    #2 rst_ni = 1'b0;
    #1;
    claim_req_i = 1'b0;
    vectors++; if ({claim_rsp_valid_o, claim_id_o, claim_o, claimed_o} !== '0) begin errors++; $display("FAIL mid_rst_claim: got rsp=%b id=%0d clm=%h map=%h want 0", claim_rsp_valid_o, claim_id_o, claim_o, claimed_o); end
    vectors++; if ({claim_ready_o, irq_o, complete_err_o, complete_o} !== '0) begin errors++; $display("FAIL mid_rst_misc: got nonzero"); end
    @(negedge clk_i); rst_ni = 1'b1;
    tick();
    vectors++; if ({claim_ready_o, claim_rsp_valid_o, claim_o} !== {1'b1, 1'b0, 32'h0}) begin errors++; $display("FAIL mid_rel: got rdy=%b rsp=%b clm=%h want 1/0/0", claim_ready_o, claim_rsp_valid_o, claim_o); end
    tick();
    vectors++; if (claimed_o !== 32'h0) begin errors++; $display("FAIL mid_bitmap: got %h want 0", claimed_o); end
  endtask

  initial begin
    test_reset();
    test_claim();
    test_claim_no_irq();
    test_complete();
    test_complete_illegal();
    test_complete_during_resp();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/rv_plic_claim_ctrl.md
Name: rv_plic_claim_ctrl

Overview:
- Per-target claim/complete controller. Consumes the registered interrupt request and winning ID from one PLIC target arbiter.
- Implements the hart-facing claim handshake (CC register read) and complete handshake (CC register write).
- Drives one-hot claim/complete pulses back to the per-source gateways and tracks the claimed set.
- Masks the hart interrupt for a fixed blanking window after each claim, so the arbiter tree and its output register can drop the claimed source.

Parameters:
- N_SOURCE, 32, number of interrupt sources; ID 0 is reserved and means "no interrupt".
- BLANK_CYCLES, 2, cycles irq_o is forced low after a claim response; legal range 1..15.
- SrcWidth, $clog2(N_SOURCE), localparam ID width.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  reset
- irq_i  input  1  registered request from target arbiter
- irq_id_i  input  SrcWidth  registered winning ID from target arbiter
- claim_req_i  input  1  claim request (CC read strobe)
- claim_ready_o  output  1  claim request accepted this cycle when high
- claim_rsp_valid_o  output  1  one-cycle claim response strobe
- claim_id_o  output  SrcWidth  claimed ID; valid with claim_rsp_valid_o
- complete_req_i  input  1  complete request (CC write strobe)
- complete_id_i  input  SrcWidth  ID being completed
- complete_err_o  output  1  one-cycle pulse on an illegal complete
- claim_o  output  N_SOURCE  one-hot claim pulse to gateways
- complete_o  output  N_SOURCE  one-hot complete pulse to gateways
- claimed_o  output  N_SOURCE  bitmap of claimed, not yet completed IDs
- irq_o  output  1  interrupt to hart, masked during blanking

Behaviour:
- Clock and reset: single clock clk_i; reset rst_ni is asynchronous, active-low.
- Reset values: all outputs 0, claimed bitmap 0, FSM in IDLE, blank counter 0.
- Reset asserted mid-operation discards any pending response or complete. No pulses are emitted afterwards.

FSM states: IDLE, RESP, BLANK.
- IDLE:
  - claim_ready_o = 1; irq_o = irq_i.
  - On claim_req_i, capture cap_id = irq_i ? irq_id_i : 0, then go to RESP.
- RESP (exactly one cycle):
  - claim_rsp_valid_o = 1; claim_id_o = cap_id; claim_ready_o = 0; irq_o = 0.
  - If cap_id != 0 and cap_id < N_SOURCE: claim_o[cap_id] = 1 and claimed[cap_id] is set (visible on claimed_o next cycle).
  - cap_id = 0 produces no claim_o pulse and no bitmap change.
  - Next state: BLANK with counter = BLANK_CYCLES.
- BLANK:
  - claim_ready_o = 0; irq_o = 0; the counter decrements each cycle.
  - Return to IDLE when the counter reaches 1, i.e. blanking lasts exactly BLANK_CYCLES cycles.
- claim_req_i while claim_ready_o = 0 is not accepted. The requester holds the request until it sees ready.
- Claim latency: request accepted in cycle N; response in cycle N+1; claim_ready_o is high again in cycle N+2+BLANK_CYCLES.
- claim_id_o is 0 whenever claim_rsp_valid_o = 0.

Complete (accepted in any FSM state, no backpressure):
- Evaluated against the registered bitmap in the request cycle. Outputs appear one cycle later.
- Legal complete (id != 0, id < N_SOURCE, claimed[id] = 1): complete_o[id] = 1 for one cycle and claimed[id] is cleared.
- Illegal complete (any other case): complete_err_o = 1 for one cycle; no complete_o pulse; bitmap unchanged.
- A complete in the same cycle as a RESP for the same ID sees the bit still clear. It is illegal and flags an error.
- Set and clear of different bits in the same cycle both take effect.

Other:
- claim_o and complete_o are at most one-hot; assertions are required for both.
- Claiming an ID already claimed returns the ID and pulses claim_o again; the bitmap stays set.

Test Plan:
- irq_i=1, irq_id_i=5, claim_req_i pulse at cycle 10 -> cycle 11: claim_rsp_valid_o=1, claim_id_o=5, claim_o=32'h20. Cycle 12: claimed_o=32'h20. irq_o low in cycles 11..13. claim_ready_o high again at cycle 14 (BLANK_CYCLES=2).
- irq_i=0, claim_req_i pulse -> claim_id_o=0 with rsp valid; claim_o=0; claimed_o unchanged.
- After claiming 5, complete_req_i with complete_id_i=5 -> next cycle complete_o=32'h20, complete_err_o=0; following cycle claimed_o=0.
- complete_id_i=7 (not claimed), then complete_id_i=0 -> complete_err_o pulses each time; complete_o=0.
- Claim 3 held in BLANK, plus a back-to-back claim_req_i -> ready=0 through blanking. The second request is accepted only in IDLE and returns the then-current irq_id_i (e.g. 9).
- rst_ni low during RESP for ID 4 -> all outputs 0 immediately. After release: claimed_o=0, no claim_o pulse, FSM in IDLE, claim_ready_o=1.
